unary_add_sched: RTL and testbench
==================================

// Module: unary_add_sched
// PURPOSE
//  Round-robin scheduler for one shared Unary_add_1_4_7 instance, serving NREQ requesters.
//  Per grant: latches two binary operands and replays them as unary pulse streams on A/B (read phase).
//  Then runs the adder's write phase and counts the dout pulses back into a binary sum.
//  Returns sum plus overflow (adder C) to the granted requester.
// PARAMETERS
//  NREQ  2  number of requesters (1..8)
//  OPW   3  operand/result width; must equal the adder counter width
// PORTS
//  clk         in   1         clock
//  rst_n       in   1         async reset, active low; also drives the adder's rst_n
//  req         in   NREQ      request; held with operands until gnt
//  op_a        in   NREQ*OPW  operand A, requester i at [i*OPW +: OPW]
//  op_b        in   NREQ*OPW  operand B, same packing
//  gnt         out  NREQ      one-hot, 1-cycle pulse; operands latched this cycle
//  done        out  1         1-cycle pulse; result valid
//  done_id     out  3         index of served requester
//  result      out  OPW       (a+b) mod 2^OPW, as counted from dout
//  result_ovf  out  1         a+b >= 2^OPW
//  chk_err     out  1         sticky self-check error (see CONFIGURATION)
//  add_en      out  1         adder en
//  add_rw      out  1         adder read_or_write (0 = read, 1 = write)
//  add_A       out  1         adder A
//  add_B       out  1         adder B
//  add_dout    in   1         adder dout
//  add_C       in   1         adder C
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; RR pointer = 0; ovf/err flags cleared. Reset is legal at any time.
//  FSM states: IDLE -> ARB -> FEED -> DRAIN -> WRITE -> DONE -> IDLE.
//  - IDLE: add_en = 0. Goes to ARB when any req is high.
//  - ARB (cycle 0): RR pick, starting at pointer.
//    - gnt[i] = 1; latch a, b and id.
//    - pointer <= i+1 (mod NREQ).
//    - m = max(a,b).
//  - FEED (cycles 1..m; skipped when m = 0): add_en = 1, add_rw = 0.
//    - FEED cycle j: add_A = (j <= a), add_B = (j <= b).
//  - DRAIN (2 cycles): add_en = 1, add_rw = 0, A = B = 0.
//    - Flushes the adder's internal overflow flag into C and clears it.
//    - Mandatory even when no overflow occurs.
//  - ovf: sticky OR of add_C sampled in every FEED and DRAIN cycle. The C pulse is 1 cycle wide.
//  - WRITE: add_en = 1, add_rw = 1.
//    - W0 issues the first decrement.
//    - From W1 on, each cycle with add_dout = 1 increments r.
//    - First cycle >= W1 with add_dout = 0 ends WRITE (adder count now 0).
//    - Length = r + 2 cycles.
//  - DONE (cycle m+r+5 after gnt): add_en = 0.
//    - done = 1; result = r; result_ovf = ovf; done_id = id. Then IDLE.
//  - Outputs: result/done_id/result_ovf hold until the next done; done, gnt are 1-cycle pulses.
//  - Arithmetic: r saturates at 2^OPW - 1 (cannot exceed it with a correct adder).
//  - Boundaries:
//    - req dropped before gnt: ignored, no penalty.
//    - req raised mid-operation: waits for IDLE.
//    - all req high: strict rotation, no requester served twice before the others.
//    - a = b = 0: no FEED, r = 0, done at cycle 5.
//    - Overflow in the last FEED cycle: C appears in DRAIN cycle 2 and must be captured.
//  - Adder en is low outside FEED/DRAIN/WRITE, so the adder holds its state between operations.
// CONFIGURATION
//  UNARY_SCHED_CHECK_EN
//  - Defined: in DONE, compare r against (a+b) mod 2^OPW and ovf against carry(a+b).
//    A mismatch sets chk_err (sticky until rst_n).
//  - Undefined: no comparator; chk_err tied 0.
// TESTING
//  1. Single req0, a=2, b=3 -> gnt[0] at cycle 0; done at cycle 13; result=5, ovf=0.
//  2. a=7, b=3 -> done at cycle 14; result=2, result_ovf=1.
//  3. a=6, b=1 (sum 7, edge) -> result=7, ovf=0.
//     a=7, b=1 -> result=0, ovf=1 (C captured in DRAIN).
//  4. a=0, b=0 -> no add_A/add_B pulse; done at cycle 5; result=0, ovf=0.
//  5. req0, req1 held high for 4 ops -> gnt order 0,1,0,1.
//     Each done_id matches its gnt; back-to-back results are correct.
//  6. rst_n low mid-FEED -> outputs 0 immediately.
//     After release, a new a=4, b=4 op -> result=0, ovf=1 (adder not polluted).
//     With UNARY_SCHED_CHECK_EN, chk_err stays 0 for all of the above.

Source files
------------

// File: rtl/unary_add_sched.sv
// Round-robin scheduler that time-shares one unary adder among NREQ requesters.
// Optional self-check comparator enabled by defining UNARY_SCHED_CHECK_EN.
module unary_add_sched #(
    parameter int NREQ = 2,
    parameter int OPW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*OPW-1:0]  op_a,
    input  logic [NREQ*OPW-1:0]  op_b,
    output logic [NREQ-1:0]      gnt,
    output logic                 done,
    output logic [2:0]           done_id,
    output logic [OPW-1:0]       result,
    output logic                 result_ovf,
    output logic                 chk_err,
    output logic                 add_en,
    output logic                 add_rw,
    output logic                 add_A,
    output logic                 add_B,
    input  logic                 add_dout,
    input  logic                 add_C
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [2:0]     ptr;
    logic [2:0]     id_q;
    logic [OPW-1:0] a_q, b_q, m_q, j_q, r_q;
    logic           drain_ph, wr_first, ovf_q;

    logic           pick_valid;
    logic [2:0]     pick_idx;
    logic [OPW-1:0] pick_a, pick_b, pick_max;

    // Round-robin search starting at the pointer
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_valid && req[(int'(ptr) + k) % NREQ]) begin
                pick_valid = 1'b1;
                pick_idx   = 3'((int'(ptr) + k) % NREQ);
            end
        end
        pick_a   = op_a[int'(pick_idx)*OPW +: OPW];
        pick_b   = op_b[int'(pick_idx)*OPW +: OPW];
        pick_max = (pick_a > pick_b) ? pick_a : pick_b;
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        done      = 1'b0;
        add_en    = 1'b0;
        add_rw    = 1'b0;
        add_A     = 1'b0;
        add_B     = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req)
                    state_nxt = S_ARB;
            end
            S_ARB: begin
                if (pick_valid) begin
                    gnt       = NREQ'(1) << pick_idx;
                    state_nxt = (pick_max == '0) ? S_DRAIN : S_FEED;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_FEED: begin
                add_en = 1'b1;
                add_A  = (j_q <= a_q);
                add_B  = (j_q <= b_q);
                if (j_q == m_q)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                add_en = 1'b1;
                if (drain_ph)
                    state_nxt = S_WRITE;
            end
            S_WRITE: begin
                add_en = 1'b1;
                add_rw = 1'b1;
                if (!wr_first && !add_dout)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Result registers load as WRITE ends so they are valid during the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            j_q        <= '0;
            r_q        <= '0;
            drain_ph   <= 1'b0;
            wr_first   <= 1'b0;
            ovf_q      <= 1'b0;
            result     <= '0;
            result_ovf <= 1'b0;
            done_id    <= '0;
        end else begin
            case (state)
                S_ARB: begin
                    if (pick_valid) begin
                        a_q      <= pick_a;
                        b_q      <= pick_b;
                        m_q      <= pick_max;
                        id_q     <= pick_idx;
                        ptr      <= 3'((int'(pick_idx) + 1) % NREQ);
                        j_q      <= OPW'(1);
                        r_q      <= '0;
                        ovf_q    <= 1'b0;
                        drain_ph <= 1'b0;
                        wr_first <= 1'b1;
                    end
                end
                S_FEED: begin
                    j_q   <= j_q + 1'b1;
                    ovf_q <= ovf_q | add_C;
                end
                S_DRAIN: begin
                    drain_ph <= 1'b1;
                    ovf_q    <= ovf_q | add_C;
                end
                S_WRITE: begin
                    if (wr_first) begin
                        wr_first <= 1'b0;
                    end else if (add_dout) begin
                        if (r_q != '1)
                            r_q <= r_q + 1'b1;
                    end else begin
                        result     <= r_q;
                        result_ovf <= ovf_q;
                        done_id    <= id_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UNARY_SCHED_CHECK_EN
    logic [OPW:0] ref_sum;
    assign ref_sum = {1'b0, a_q} + {1'b0, b_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chk_err <= 1'b0;
        else if (state == S_DONE &&
                 (r_q != ref_sum[OPW-1:0] || ovf_q != ref_sum[OPW]))
            chk_err <= 1'b1;
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_unary_add_sched.sv
// Directed bench for unary_add_sched with a behavioural model of the shared unary adder.
module tb_unary_add_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [5:0] op_a, op_b;
    logic [1:0] gnt;
    logic       done;
    logic [2:0] done_id;
    logic [2:0] result;
    logic       result_ovf, chk_err;
    logic       add_en, add_rw, add_A, add_B, add_dout, add_C;

    int n_vec  = 0;
    int n_miss = 0;

    unary_add_sched #(.NREQ(2), .OPW(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .done(done), .done_id(done_id), .result(result),
        .result_ovf(result_ovf), .chk_err(chk_err), .add_en(add_en),
        .add_rw(add_rw), .add_A(add_A), .add_B(add_B),
        .add_dout(add_dout), .add_C(add_C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: read adds A+B, wrap sets a flag that surfaces on C one cycle later;
    // write decrements and reports each successful decrement on dout the next cycle.
    logic [2:0] m_cnt;
    logic       m_flag;
    logic [3:0] m_sum;
    assign m_sum = {1'b0, m_cnt} + {3'b0, add_A} + {3'b0, add_B};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= '0;
            m_flag   <= 1'b0;
            add_C    <= 1'b0;
            add_dout <= 1'b0;
        end else if (add_en && !add_rw) begin
            m_cnt    <= m_sum[2:0];
            add_C    <= m_flag;
            m_flag   <= m_sum[3];
            add_dout <= 1'b0;
        end else if (add_en && add_rw) begin
            add_C <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt    <= m_cnt - 1'b1;
                add_dout <= 1'b1;
            end else begin
                add_dout <= 1'b0;
            end
        end else begin
            add_C <= 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_op(input int idx, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] exp_res, input logic exp_ovf,
                          input int exp_cyc, input string tag);
        bit seen;
        int cyc, cnt_a, cnt_b;
        @(negedge clk);
        req[idx]            = 1'b1;
        op_a[idx*3 +: 3]    = a;
        op_b[idx*3 +: 3]    = b;
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (gnt != 0) seen = 1;
        end
        n_vec++;
        if (!seen) begin
            n_miss++;
            $display("[TB] FAIL %s gnt: timeout waiting for grant, required %b", tag, 2'b01 << idx);
        end else if (gnt !== (2'b01 << idx)) begin
            n_miss++;
            $display("[TB] FAIL %s gnt: got %b, required %b", tag, gnt, 2'b01 << idx);
        end
        @(posedge clk);
        #1 req[idx] = 1'b0;
        cyc = 0; cnt_a = 0; cnt_b = 0; seen = 0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            cyc++;
            if (add_en && !add_rw && add_A) cnt_a++;
            if (add_en && !add_rw && add_B) cnt_b++;
            if (cyc == 1) begin
                n_vec++;
                if (gnt !== 2'b00) begin
                    n_miss++;
                    $display("[TB] FAIL %s gnt_pulse: got %b, required 00", tag, gnt);
                end
            end
            if (done) seen = 1;
        end
        n_vec++;
        if (!seen) begin
            n_miss++;
            $display("[TB] FAIL %s done: timeout after %0d cycles", tag, cyc);
        end else begin
            n_vec += 7;
            if (cyc != exp_cyc) begin
                n_miss++;
                $display("[TB] FAIL %s done_cycle: got %0d, required %0d", tag, cyc, exp_cyc);
            end
            if (result !== exp_res) begin
                n_miss++;
                $display("[TB] FAIL %s result: got %0d, required %0d", tag, result, exp_res);
            end
            if (result_ovf !== exp_ovf) begin
                n_miss++;
                $display("[TB] FAIL %s ovf: got %b, required %b", tag, result_ovf, exp_ovf);
            end
            if (done_id !== 3'(idx)) begin
                n_miss++;
                $display("[TB] FAIL %s done_id: got %0d, required %0d", tag, done_id, idx);
            end
            if (cnt_a != int'(a) || cnt_b != int'(b)) begin
                n_miss++;
                $display("[TB] FAIL %s pulses: got A=%0d B=%0d, required A=%0d B=%0d",
                         tag, cnt_a, cnt_b, a, b);
            end
            if (chk_err !== 1'b0) begin
                n_miss++;
                $display("[TB] FAIL %s chk_err: got %b, required 0", tag, chk_err);
            end
            @(negedge clk);
            if (done !== 1'b0 || result !== exp_res) begin
                n_miss++;
                $display("[TB] FAIL %s done_hold: got done=%b result=%0d, required 0/%0d",
                         tag, done, result, exp_res);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({gnt, done, done_id, result, result_ovf, chk_err, add_en, add_rw, add_A, add_B} !== '0) begin
            n_miss++;
            $display("[TB] FAIL reset_outputs: got gnt=%b done=%b id=%0d res=%0d ovf=%b err=%b en=%b, required all 0",
                     gnt, done, done_id, result, result_ovf, chk_err, add_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(0, 3'd2, 3'd3, 3'd5, 1'b0, 13, "basic_2p3");
    endtask

    task automatic test_overflow();
        run_op(0, 3'd7, 3'd3, 3'd2, 1'b1, 14, "ovf_7p3");
    endtask

    task automatic test_edge();
        run_op(0, 3'd6, 3'd1, 3'd7, 1'b0, 18, "edge_6p1");
        run_op(0, 3'd7, 3'd1, 3'd0, 1'b1, 12, "edge_7p1");
    endtask

    task automatic test_zero();
        run_op(1, 3'd0, 3'd0, 3'd0, 1'b0, 5, "zero_0p0");
    endtask

    task automatic test_reset_mid_feed();
        bit seen;
        @(negedge clk);
        req[0] = 1'b1; op_a[2:0] = 3'd5; op_b[2:0] = 3'd5;
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (gnt != 0) seen = 1;
        end
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (!seen || add_en !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL midrst_infeed: got gnt_seen=%b add_en=%b, required 1/1", seen, add_en);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({gnt, done, done_id, result, result_ovf, chk_err, add_en, add_A, add_B} !== '0) begin
            n_miss++;
            $display("[TB] FAIL midrst_outputs: got res=%0d ovf=%b en=%b A=%b B=%b, required all 0",
                     result, result_ovf, add_en, add_A, add_B);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 3'd4, 3'd4, 3'd0, 1'b1, 9, "midrst_4p4");
    endtask

    task automatic test_back_to_back();
        bit seen;
        int exp;
        do_reset();
        @(negedge clk);
        op_a = {3'd3, 3'd1};
        op_b = {3'd4, 3'd2};
        req  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp  = k % 2;
            seen = 0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk);
                if (gnt != 0) seen = 1;
            end
            n_vec++;
            if (!seen || gnt !== (2'b01 << exp)) begin
                n_miss++;
                $display("[TB] FAIL b2b_gnt%0d: got %b, required %b", k, gnt, 2'b01 << exp);
            end
            if (k == 3) begin
                @(posedge clk);
                #1 req = 2'b00;
            end
            seen = 0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            n_vec++;
            if (!seen || done_id !== 3'(exp) || result !== (exp == 1 ? 3'd7 : 3'd3) || result_ovf !== 1'b0) begin
                n_miss++;
                $display("[TB] FAIL b2b_done%0d: got seen=%b id=%0d res=%0d ovf=%b, required 1/%0d/%0d/0",
                         k, seen, done_id, result, result_ovf, exp, (exp == 1 ? 7 : 3));
            end
        end
        n_vec++;
        if (chk_err !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL b2b_chk_err: got %b, required 0", chk_err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_reset_mid_feed();
        test_edge();
        test_zero();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
